// File: rtl/frame_diff_motion_pkg.sv
// Shared defaults and pipeline control type for the frame-difference motion stage.
package frame_diff_motion_pkg;

  localparam int PIX_WIDTH    = 8;
  localparam int H_PIXELS     = 320;
  localparam int V_PIXELS     = 180;
  localparam int FRAME_PIXELS = H_PIXELS * V_PIXELS;

  typedef struct packed {
    logic valid;
    logic sof;
    logic last;
  } pix_ctrl_t;

endpackage

// File: rtl/frame_diff_motion_pipe_delay.sv
// Fixed-depth shift register that carries pixel payloads alongside the RAM read latency.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/frame_diff_motion.sv
// Streams pixels into a read-first frame BRAM and compares each against the previous frame's pixel.
module frame_diff_motion #(
  parameter int PIX_WIDTH   = frame_diff_motion_pkg::PIX_WIDTH,
  parameter int H_PIXELS    = frame_diff_motion_pkg::H_PIXELS,
  parameter int V_PIXELS    = frame_diff_motion_pkg::V_PIXELS,
  parameter int ADDR_WIDTH  = 16,
  parameter int RAM_LATENCY = 2
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  pix_valid_in,
  input  logic                  pix_sof_in,
  input  logic [PIX_WIDTH-1:0]  pix_in,
  input  logic [PIX_WIDTH-1:0]  threshold_in,
  output logic [ADDR_WIDTH-1:0] ram_addr_out,
  output logic [PIX_WIDTH-1:0]  ram_din_out,
  output logic                  ram_we_out,
  output logic                  ram_en_out,
  output logic                  ram_regce_out,
  input  logic [PIX_WIDTH-1:0]  ram_dout_in,
  output logic                  diff_valid_out,
  output logic [PIX_WIDTH-1:0]  diff_out,
  output logic                  motion_out,
  output logic                  frame_done_out,
  output logic [ADDR_WIDTH:0]   motion_count_out,
  output logic                  frame_primed_out
);
  import frame_diff_motion_pkg::pix_ctrl_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(H_PIXELS * V_PIXELS - 1);
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int PW    = $bits(pix_ctrl_t) + 2 * PIX_WIDTH;

  function automatic logic [PIX_WIDTH-1:0] abs_diff(input logic [PIX_WIDTH-1:0] a,
                                                    input logic [PIX_WIDTH-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d, addr_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [PIX_WIDTH-1:0]  ram_din_q, thr_q, thr_d;
  logic                  ram_we_q;
  pix_ctrl_t             ctrl_in, ctrl_p;
  logic [PIX_WIDTH-1:0]  thr_p, pix_p;
  logic [PW-1:0]         pipe_in, pipe_out;

  // Accept stage: SOF restarts the address, otherwise it follows the running counter.
  always_comb begin
    addr_d         = pix_sof_in ? '0 : next_addr_q;
    next_addr_d    = next_addr_q;
    thr_d          = thr_q;
    if (pix_valid_in) begin
      next_addr_d = (addr_d == LAST_ADDR) ? '0 : addr_d + 1'b1;
      if (pix_sof_in) thr_d = threshold_in;
    end
    ctrl_in.valid = pix_valid_in;
    ctrl_in.sof   = pix_valid_in & pix_sof_in;
    ctrl_in.last  = pix_valid_in & (addr_d == LAST_ADDR);
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      next_addr_q <= '0;
      thr_q       <= '0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_we_q    <= 1'b0;
    end else begin
      next_addr_q <= next_addr_d;
      thr_q       <= thr_d;
      ram_we_q    <= pix_valid_in;
      if (pix_valid_in) begin
        ram_addr_q <= addr_d;
        ram_din_q  <= pix_in;
      end
    end
  end

  // Threshold travels with each pixel so a new frame's value never leaks into the old frame's tail.
  assign pipe_in = {ctrl_in, thr_d, pix_in};

  pipe_delay #(
    .WIDTH(PW),
    .DEPTH(RAM_LATENCY + 1)
  ) u_pipe (
    .clk_i(clka),
    .rst_i(rsta),
    .d_i  (pipe_in),
    .q_o  (pipe_out)
  );

  assign {ctrl_p, thr_p, pix_p} = pipe_out;

  logic [PIX_WIDTH-1:0] diff_c, diff_q;
  logic                 hit_c, motion_q, diff_valid_q, frame_done_q;
  logic                 primed_q, primed_d;
  logic [CNT_W-1:0]     acc_q, acc_d, count_q, count_d, frame_sum;

  // Compare stage: aligned with the RAM's previous-frame pixel.
  assign diff_c    = abs_diff(pix_p, ram_dout_in);
  assign hit_c     = ctrl_p.valid & primed_q & (diff_c > thr_p);
  assign frame_sum = (ctrl_p.sof ? '0 : acc_q) + CNT_W'(hit_c);

  always_comb begin
    acc_d    = acc_q;
    count_d  = count_q;
    primed_d = primed_q;
    if (ctrl_p.valid) begin
      if (ctrl_p.last) begin
        acc_d    = '0;
        count_d  = frame_sum;
        primed_d = 1'b1;
      end else begin
        acc_d = frame_sum;
      end
    end
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      diff_valid_q <= 1'b0;
      diff_q       <= '0;
      motion_q     <= 1'b0;
      frame_done_q <= 1'b0;
      acc_q        <= '0;
      count_q      <= '0;
      primed_q     <= 1'b0;
    end else begin
      diff_valid_q <= ctrl_p.valid;
      motion_q     <= hit_c;
      frame_done_q <= ctrl_p.valid & ctrl_p.last;
      acc_q        <= acc_d;
      count_q      <= count_d;
      primed_q     <= primed_d;
      if (ctrl_p.valid) diff_q <= diff_c;
    end
  end

  assign ram_addr_out     = ram_addr_q;
  assign ram_din_out      = ram_din_q;
  assign ram_we_out       = ram_we_q;
  assign ram_en_out       = ~rsta;
  assign ram_regce_out    = ~rsta;
  assign diff_valid_out   = diff_valid_q;
  assign diff_out         = diff_q;
  assign motion_out       = motion_q;
  assign frame_done_out   = frame_done_q;
  assign motion_count_out = count_q;
  assign frame_primed_out = primed_q;

endmodule
